// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared encodings for the imem byte-stream loader
package imem_loader_pkg;

  localparam int LEN_WIDTH = 16;

  localparam logic [2:0] LOADER_STATE_IDLE       = 3'd0;
  localparam logic [2:0] LOADER_STATE_GET_LEN_HI = 3'd1;
  localparam logic [2:0] LOADER_STATE_GET_LEN_LO = 3'd2;
  localparam logic [2:0] LOADER_STATE_GET_DATA   = 3'd3;
  localparam logic [2:0] LOADER_STATE_GET_CHK    = 3'd4;
  localparam logic [2:0] LOADER_STATE_DONE       = 3'd5;
  localparam logic [2:0] LOADER_STATE_ERROR      = 3'd6;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs payload bytes MSB-first into words
// and keeps the running payload XOR; word_ready_o is a registered one-cycle pulse.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_last_o,
  output logic        word_ready_o,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] word_q, word_d;
  logic        ready_q, ready_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    word_d  = word_q;
    ready_d = 1'b0;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
      xor_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
      xor_d   = xor_q ^ byte_i;
      if (cnt_q == 2'd3) begin
        word_d  = {shift_q, byte_i};
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

  assign word_last_o  = (cnt_q == 2'd3);
  assign word_ready_o = ready_q;
  assign word_o       = word_q;
  assign xor_o        = xor_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing big-endian words into imem
// and holding the CPU until a checksum-verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  logic [2:0]           state_q, state_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [31:0]          addr_q, addr_d;

  logic                 accept, idle_like, clear, word_last, word_done;
  logic [LEN_WIDTH-1:0] rx_len;
  logic [7:0]           run_xor;

  assign rx_ready_o = (state_q == LOADER_STATE_GET_LEN_HI) || (state_q == LOADER_STATE_GET_LEN_LO) ||
                      (state_q == LOADER_STATE_GET_DATA)   || (state_q == LOADER_STATE_GET_CHK);
  assign idle_like  = (state_q == LOADER_STATE_IDLE) || (state_q == LOADER_STATE_DONE) ||
                      (state_q == LOADER_STATE_ERROR);
  assign accept     = rx_valid_i && rx_ready_o;
  assign clear      = start_i && idle_like;
  assign word_done  = accept && (state_q == LOADER_STATE_GET_DATA) && word_last;
  assign rx_len     = {len_hi_q, rx_data_i};

  loader_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .byte_valid_i (accept && (state_q == LOADER_STATE_GET_DATA)),
    .byte_i       (rx_data_i),
    .word_last_o  (word_last),
    .word_ready_o (mem_we_o),
    .word_o       (mem_wdata_o),
    .xor_o        (run_xor)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    case (state_q)
      LOADER_STATE_IDLE, LOADER_STATE_DONE, LOADER_STATE_ERROR: begin
        if (start_i) begin
          state_d    = LOADER_STATE_GET_LEN_HI;
          word_cnt_d = '0;
        end
      end
      LOADER_STATE_GET_LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data_i;
          state_d  = LOADER_STATE_GET_LEN_LO;
        end
      end
      LOADER_STATE_GET_LEN_LO: begin
        if (accept) begin
          len_d = rx_len;
          if (32'(rx_len) > (32'd1 << ADDR_WIDTH)) state_d = LOADER_STATE_ERROR;
          else if (rx_len == '0)                   state_d = LOADER_STATE_GET_CHK;
          else                                     state_d = LOADER_STATE_GET_DATA;
        end
      end
      LOADER_STATE_GET_DATA: begin
        // Address is latched with the 4th byte so it lines up with the registered write strobe.
        if (word_done) begin
          addr_d     = BASE_ADDR + (32'(word_cnt_q) << 2);
          word_cnt_d = word_cnt_q + (LEN_WIDTH+1)'(1);
          if (word_cnt_d == {1'b0, len_q}) state_d = LOADER_STATE_GET_CHK;
        end
      end
      LOADER_STATE_GET_CHK: begin
        if (accept) state_d = (rx_data_i == run_xor) ? LOADER_STATE_DONE : LOADER_STATE_ERROR;
      end
      default: state_d = LOADER_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOADER_STATE_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign cpu_hold_o = (state_q != LOADER_STATE_DONE);
  assign done_o     = (state_q == LOADER_STATE_DONE);
  assign error_o    = (state_q == LOADER_STATE_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fails++;
      $display("FAIL rx_ready_timeout: observed %0d cycles expected < 20", n);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_basic(input logic [7:0] chk, input int max_gap, input int start_at);
    logic [7:0] f [0:10];
    f = '{8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h00, 8'h20, 8'h05, 8'h00, 8'h02, 8'h00};
    f[10] = chk;
    for (int i = 0; i < 11; i++) begin
      if (max_gap > 0) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(1, max_gap)) @(posedge clk);
        #1;
      end
      if (i == start_at) start = 1'b1;
      send_byte(f[i]);
      start = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cpu_hold"}, cpu_hold, 1);
    check({pfx, "_mem_we"}, mem_we, 0);
    check({pfx, "_mem_addr"}, mem_addr, 32'h0);
    check({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_rx_ready"}, rx_ready, 0);
  endtask

  task automatic check_basic_writes(input string pfx);
    check({pfx, "_wr_cnt"}, wr_cnt, 2);
    check({pfx, "_addr0"}, wr_addr[0], 32'h0000_0000);
    check({pfx, "_data0"}, wr_data[0], 32'h2004_0000);
    check({pfx, "_addr1"}, wr_addr[1], 32'h0000_0004);
    check({pfx, "_data1"}, wr_data[1], 32'h2005_0002);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic load, with a start pulse coinciding with a payload byte
    wr_cnt = 0;
    pulse_start();
    check("basic_rx_ready", rx_ready, 1);
    send_basic(8'h03, 0, 3);
    check("basic_done", done, 1);
    check("basic_cpu_hold", cpu_hold, 0);
    check("basic_error", error, 0);
    check("basic_rx_ready_done", rx_ready, 0);
    check_basic_writes("basic");

    // empty image
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("empty_done", done, 1);
    check("empty_wr_cnt", wr_cnt, 0);

    // bad checksum
    wr_cnt = 0;
    pulse_start();
    send_basic(8'h04, 0, -1);
    check("badchk_error", error, 1);
    check("badchk_done", done, 0);
    check("badchk_cpu_hold", cpu_hold, 1);
    check_basic_writes("badchk");

    // oversize length 0x0401
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    check("oversize_error", error, 1);
    check("oversize_rx_ready", rx_ready, 0);
    repeat (3) @(posedge clk); #1;
    check("oversize_wr_cnt", wr_cnt, 0);

    // exactly capacity (0x0400) is accepted
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    check("maxlen_error", error, 0);
    check("maxlen_rx_ready", rx_ready, 1);
    rst_n = 1'b0; #1;
    check("maxlen_reset_rx_ready", rx_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // gapped stream
    wr_cnt = 0;
    pulse_start();
    send_basic(8'h03, 3, -1);
    check("gap_done", done, 1);
    check("gap_cpu_hold", cpu_hold, 0);
    check_basic_writes("gap");

    // reset mid-word, then restart
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h20); send_byte(8'h04);
    rst_n = 1'b0; #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr_cnt = 0;
    pulse_start();
    send_basic(8'h03, 0, -1);
    check("restart_done", done, 1);
    check("restart_cpu_hold", cpu_hold, 0);
    check_basic_writes("restart");
    pulse_start();
    check("rehold_cpu_hold", cpu_hold, 1);
    check("rehold_done", done, 0);
    check("rehold_rx_ready", rx_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
